// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID boundary register with 2-entry skid buffer and flush
module if_id_pipe #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_instr_o,
    input  logic            flush_i,
    output logic [1:0]      occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] m_pc, s_pc;
    logic [31:0]     m_instr, s_instr;
    logic            acc, iss;
    logic            load_m_in, load_m_skid, load_s;

    // Handshake flags depend on the state register only, so fetch never sees id_ready_i.
    assign if_ready_o = (state != TWO);
    assign id_valid_o = (state != EMPTY);
    assign occ_o      = state;
    assign id_pc_o    = m_pc;
    assign id_instr_o = m_instr;

    assign acc = if_valid_i & if_ready_o;
    assign iss = id_valid_o & id_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && !iss) begin
                    state_nxt = TWO;
                    load_s    = 1'b1;
                end else if (!acc && iss) begin
                    state_nxt = EMPTY;
                end else if (acc && iss) begin
                    load_m_in = 1'b1;
                end
            end
            TWO: begin
                if (iss) begin
                    state_nxt   = ONE;
                    load_m_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Redirect wins: pairs accepted this cycle are dropped and payload is left as-is.
        if (flush_i) begin
            state_nxt   = EMPTY;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= '0;
            m_instr <= NOP_INSTR;
            s_pc    <= '0;
            s_instr <= '0;
        end else begin
            if (load_m_in) begin
                m_pc    <= if_pc_i;
                m_instr <= if_instr_i;
            end else if (load_m_skid) begin
                m_pc    <= s_pc;
                m_instr <= s_instr;
            end
            if (load_s) begin
                s_pc    <= if_pc_i;
                s_instr <= if_instr_i;
            end
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - scoreboard bench for if_id_pipe
module tb_if_id_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        flush;
    logic [1:0]  occ;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_pc[$];
    logic [31:0] sb_instr[$];

    if_id_pipe #(.XLEN(64), .NOP_INSTR(32'h0000_0013)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid_i (if_valid),
        .if_ready_o (if_ready),
        .if_pc_i    (if_pc),
        .if_instr_i (if_instr),
        .id_valid_o (id_valid),
        .id_ready_i (id_ready),
        .id_pc_o    (id_pc),
        .id_instr_o (id_instr),
        .flush_i    (flush),
        .occ_o      (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_instr = instr;
        id_ready = rdy;
        flush    = fl;
    endtask

    task automatic compare_outputs();
        check("occ", {62'b0, occ}, 64'(sb_pc.size()));
        check("if_ready", {63'b0, if_ready}, {63'b0, sb_pc.size() < 2});
        check("id_valid", {63'b0, id_valid}, {63'b0, sb_pc.size() > 0});
        if (sb_pc.size() > 0 && id_valid) begin
            check("id_pc", id_pc, sb_pc[0]);
            check("id_instr", {32'b0, id_instr}, {32'b0, sb_instr[0]});
        end
    endtask

    // One clock: update the reference buffer at the edge, compare on the falling edge.
    task automatic cycle();
        bit acc, iss;
        @(posedge clk);
        acc = if_valid && (sb_pc.size() < 2);
        iss = id_ready && (sb_pc.size() > 0);
        if (flush) begin
            sb_pc.delete();
            sb_instr.delete();
        end else begin
            if (iss) begin
                void'(sb_pc.pop_front());
                void'(sb_instr.pop_front());
            end
            if (acc) begin
                sb_pc.push_back(if_pc);
                sb_instr.push_back(if_instr);
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_id_valid"}, {63'b0, id_valid}, 64'd0);
        check({tag, "_if_ready"}, {63'b0, if_ready}, 64'd1);
        check({tag, "_id_pc"}, id_pc, 64'd0);
        check({tag, "_id_instr"}, {32'b0, id_instr}, 64'h13);
        check({tag, "_occ"}, {62'b0, occ}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Stream at full rate
        drive(1'b1, 64'h8000_0000, 32'h0000_0001, 1'b1, 1'b0); cycle();
        check("stream_first_valid", {63'b0, id_valid}, 64'd1);
        drive(1'b1, 64'h8000_0004, 32'h0000_0002, 1'b1, 1'b0); cycle();
        drive(1'b1, 64'h8000_0008, 32'h0000_0003, 1'b1, 1'b0); cycle();
        check("stream_last_pc", id_pc, 64'h8000_0008);
        drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0); cycle();

        // Backpressure into the skid register
        drive(1'b1, 64'h8000_0000, 32'h0000_0011, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h8000_0004, 32'h0000_0012, 1'b0, 1'b0); cycle();
        check("bp_occ2", {62'b0, occ}, 64'd2);
        check("bp_ready_low", {63'b0, if_ready}, 64'd0);
        drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0); cycle();
        check("bp_ready_back", {63'b0, if_ready}, 64'd1);
        check("bp_second_pc", id_pc, 64'h8000_0004);
        cycle();

        // Flush while full
        drive(1'b1, 64'h8000_0020, 32'h0050_0093, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h8000_0024, 32'h00A0_0113, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b1); cycle();
        check("flush_valid", {63'b0, id_valid}, 64'd0);
        check("flush_occ", {62'b0, occ}, 64'd0);
        drive(1'b1, 64'h8000_0100, 32'h0000_0021, 1'b1, 1'b0); cycle();
        check("after_flush_pc", id_pc, 64'h8000_0100);
        drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0); cycle();

        // Accept coinciding with flush is dropped
        drive(1'b1, 64'h8000_0010, 32'h0000_0031, 1'b1, 1'b1);
        check("flush_acc_ready", {63'b0, if_ready}, 64'd1);
        cycle();
        check("flush_acc_empty", {62'b0, occ}, 64'd0);
        drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0); cycle();

        // Asynchronous reset while full
        drive(1'b1, 64'h8000_0040, 32'h0000_0041, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h8000_0044, 32'h0000_0042, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        sb_pc.delete();
        sb_instr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        compare_outputs();

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(1), {32'h8000_0000, $urandom}, $urandom,
                  $urandom_range(1), $urandom_range(99) < 2);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Pipeline boundary register between instruction fetch and decode in the 5-stage core. Captures each fetched (pc, instr) pair and presents it to the ID stage through a valid/ready handshake. A 2-entry skid buffer keeps the fetch side's ready fully registered, with no combinational path from id_ready_i. A synchronous flush from the jump/branch resolution logic discards wrong-path instructions.

## Interface
- XLEN, 64, width of PC datapath
- NOP_INSTR, 32'h0000_0013, instruction value loaded into the main payload register at reset (addi x0,x0,0)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- if_valid_i  input  1  fetch offers a (pc, instr) pair this cycle
- if_ready_o  output  1  buffer can accept a pair this cycle
- if_pc_i  input  XLEN  PC of offered instruction
- if_instr_i  input  32  offered instruction word
- id_valid_o  output  1  a pair is presented to decode
- id_ready_i  input  1  decode consumes the presented pair this cycle
- id_pc_o  output  XLEN  PC of presented instruction
- id_instr_o  output  32  presented instruction word
- flush_i  input  1  redirect: discard all buffered and incoming pairs
- occ_o  output  2  number of buffered pairs (0..2), debug/perf

## Operation
- Accept: acc = if_valid_i & if_ready_o. Issue: iss = id_valid_o & id_ready_i.
- Storage: main register (M) drives id_* outputs; skid register (S) holds the overflow pair.
- States: EMPTY (occ 0), ONE (M valid), TWO (M and S valid). occ_o is the state encoding directly.
- if_ready_o = (state != TWO). It is a function of state only.
- id_valid_o = (state != EMPTY). id_pc_o/id_instr_o = M payload.
- Transitions (flush_i = 0):
  - EMPTY: acc -> ONE, M <= input. !acc -> EMPTY.
  - ONE: acc & !iss -> TWO, S <= input. !acc & iss -> EMPTY. acc & iss -> ONE, M <= input. Neither -> ONE, hold.
  - TWO: iss -> ONE, M <= S. !iss -> TWO, hold. acc is impossible.
- flush_i = 1 has highest priority. Next state is EMPTY regardless of acc/iss. A pair accepted in the flush cycle is dropped. Payload registers hold their values.
- The handshake still completes in a flush cycle: if_ready_o and id_valid_o reflect the current state. Decode may consume M in that cycle, and fetch treats an accepted pair as consumed.
- Ordering: pairs leave in strict acceptance order. There is no duplication and no loss except by flush.
- Payload outputs are meaningful only while id_valid_o = 1. The bench must not check them otherwise.
- Reset (async, any time, including mid-transfer): state EMPTY, M = {pc 0, instr NOP_INSTR}, S = {0, 0}.
- Reset output values: if_ready_o = 1, id_valid_o = 0, id_pc_o = 0, id_instr_o = NOP_INSTR, occ_o = 0.

## Timing
- Latency: a pair accepted at edge N appears on id_* with id_valid_o = 1 after edge N (1 cycle) when the buffer was EMPTY, or when ONE with a simultaneous issue.
- Throughput: 1 pair/cycle sustained while id_ready_i = 1.
- Backpressure: after id_ready_i drops, one more pair can be accepted (into S). if_ready_o falls on the following edge.
- if_ready_o and id_valid_o are flop outputs. There are no combinational input-to-output paths except the payload mux-free M outputs.
- flush_i takes effect at the next rising edge. id_valid_o = 0 in the cycle after flush.

## Test plan
- Reset/stream: release rst_n with id_ready_i = 1. Offer pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles. Required: id_valid_o rises 1 cycle after the first acceptance, pcs emerge in order one per cycle, occ_o stays at or below 1, and if_ready_o stays 1.
- Backpressure: with id_ready_i = 0 and the buffer ONE (pc 0x8000_0000), offer 0x8000_0004. Required: it is accepted, occ_o = 2, and if_ready_o = 0 next cycle. Then raise id_ready_i. Required: 0x8000_0000 then 0x8000_0004 are issued, and if_ready_o returns to 1 after the first issue.
- Flush in TWO: fill with instrs 0x00500093, 0x00A00113, then assert flush_i for 1 cycle. Required: id_valid_o = 0 and occ_o = 0 next cycle. A following offer of pc 0x8000_0100 is the next pair issued.
- Flush with simultaneous accept: buffer EMPTY, if_valid_i = 1 (pc 0x8000_0010) and flush_i = 1 in the same cycle. Required: the pair is accepted (if_ready_o = 1) but never appears, and state stays EMPTY.
- Async reset mid-operation: in state TWO, pulse rst_n low between clock edges. Required: id_valid_o = 0, if_ready_o = 1, id_instr_o = 32'h0000_0013, id_pc_o = 0, and occ_o = 0 immediately, without waiting for a clock edge.
- Random scoreboard: 10k cycles of random if_valid_i, id_ready_i, and 2%-rate flush_i. Required: every issued pair matches the next unflushed accepted pair in order, and occ_o never exceeds 2.
